// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Purpose: runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on two register
// operands. Every op takes a fixed WIDTH iterations. The unit holds the
// write-back result for one cycle, marked by done.
//
// Ports:
//   clk        system clock; all state updates on posedge
//   rst        asynchronous, active-high reset
//   start      request pulse; sampled only in IDLE
//   funct3     op select (000 MUL .. 111 REMU)
//   rs1Data    operand A (multiplicand / dividend)
//   rs2Data    operand B (multiplier / divisor)
//   rdIn       destination register index
//   busy       high in CALC and DONE
//   done       one-cycle pulse, result valid
//   result     write-back data, held until the next DONE or rst
//   rdOut      latched destination index
//   WE         register-file write enable: done && rdOut != 0
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a request is accepted on a posedge where start=1 and busy=0.
// Operands, funct3 and rdIn are captured at that edge and may change
// afterwards. busy stays high until the posedge that ends the done cycle.
// start while busy (including the done cycle) is ignored. done pulses for
// exactly one cycle, WIDTH cycles after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1Data,
  input  logic [WIDTH-1:0] rs2Data,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rdOut,
  output logic             WE,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         f3;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;    // mul: |A|; div: |B|
  logic [WIDTH-1:0]   a_raw;   // original rs1Data, needed for REM by zero
  logic               neg_q;   // product / quotient sign
  logic               neg_r;   // remainder sign
  logic               div0;
  logic               ovf;

  // Operand preparation at accept
  logic               in_div;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    in_div = funct3[2];
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin sgn_a = rs1Data[WIDTH-1]; sgn_b = rs2Data[WIDTH-1]; end
      3'b010:                 sgn_a = rs1Data[WIDTH-1];
      default: ;
    endcase
    mag_a = sgn_a ? -rs1Data : rs1Data;
    mag_b = sgn_b ? -rs2Data : rs2Data;
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (f3[2]) begin
      // Non-negative trial difference means the divisor fits: keep it, quotient bit 1
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // Final result from the last iteration's value, with sign fix and special cases
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, final_res;

  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    if (!f3[2]) begin
      final_res = (f3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (div0) begin
      final_res = f3[1] ? a_raw : '1;
    end else if (ovf && !f3[0]) begin
      final_res = f3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      final_res = f3[1] ? rem : quo;
    end
  end

  logic last_iter;
  assign last_iter = (state_q == CALC) && (cnt == CW'(WIDTH - 1));

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3     <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
      rdOut  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        f3    <= funct3;
        rdOut <= rdIn;
        a_raw <= rs1Data;
        cnt   <= '0;
        acc   <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
        opnd  <= in_div ? mag_b : mag_a;
        neg_q <= sgn_a ^ sgn_b;
        neg_r <= sgn_a;
        div0  <= (rs2Data == '0);
        ovf   <= (rs1Data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2Data == '1);
      end else if (state_q == CALC) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (last_iter) result <= final_res;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign WE        = done && (rdOut != 5'd0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1Data, rs2Data;
  logic [4:0]  rdIn;
  logic        busy, done, WE;
  logic [31:0] result;
  logic [4:0]  rdOut;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .rdIn(rdIn),
    .busy(busy), .done(done), .result(result), .rdOut(rdOut),
    .WE(WE), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait up to 'bound' posedges for done; returns the number of edges waited
  task automatic wait_done(input int bound, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
  endtask

  // Driver: issue one op from IDLE, check latency, result, rdOut, WE.
  // Called just after a posedge with the unit idle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    bit seen;
    exp_q.push_back(exp);
    funct3 = f; rs1Data = a; rs2Data = b; rdIn = rd; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    rs1Data = $urandom;
    rs2Data = $urandom;
    funct3  = 3'($urandom_range(0, 7));
    rdIn    = 5'($urandom_range(0, 31));
    wait_done(40, lat, seen);
    check({tag, "_latency"}, 32'(lat), 32'd32);
    if (seen) begin
      check({tag, "_result"}, result, exp_q.pop_front());
      check({tag, "_rdout"}, {27'd0, rdOut}, {27'd0, rd});
      check({tag, "_we"}, {31'd0, WE}, {31'd0, (rd != 5'd0)});
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    end else begin
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin : stim
    int lat;
    bit seen;
    int t1;

    rst = 1'b1; start = 1'b0; funct3 = '0; rs1Data = '0; rs2Data = '0; rdIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, WE, state_dbg, 27'd0}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rdout", {27'd0, rdOut}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-op: abort at iteration 10, no done
    funct3 = 3'b000; rs1Data = 32'd7; rs2Data = 32'd6; rdIn = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {30'd0, busy, done}, 32'd0);
    check("abort_we", {31'd0, WE}, 32'd0);
    check("abort_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("mul_after_rst", 3'b000, 32'd7, 32'd6, 5'd3, 32'd42);

    // Multiply signs
    run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFE);
    run_op("mulh",   3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd2, 32'hFFFF_FFFF);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 32'hFFFF_FFFF);

    // Divide signs
    run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2);

    // Special cases
    run_op("div_by0",  3'b100, 32'd5, 32'd0, 5'd9,  32'hFFFF_FFFF);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd10, 32'd5);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

    // Write-enable gating
    run_op("we_rd0", 3'b000, 32'd3, 32'd3, 5'd0, 32'd9);
    run_op("we_rd5", 3'b000, 32'd3, 32'd3, 5'd5, 32'd9);

    // start held high: one op per 34 cycles, operand changes while busy ignored
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd15);
    funct3 = 3'b000; rs1Data = 32'd3; rs2Data = 32'd5; rdIn = 5'd1; start = 1'b1;
    wait_done(40, lat, seen);
    check("held_first_latency", 32'(lat), 32'd33);
    t1 = cyc;
    if (seen) check("held_first_result", result, exp_q.pop_front());
    else      void'(exp_q.pop_front());
    @(posedge clk); #1;
    check("held_idle_gap", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("held_reaccept", {31'd0, busy}, 32'd1);
    rs1Data = 32'd100; rs2Data = 32'd100; funct3 = 3'b111;
    wait_done(40, lat, seen);
    check("held_period", 32'(cyc - t1), 32'd34);
    if (seen) check("held_second_result", result, exp_q.pop_front());
    else      void'(exp_q.pop_front());
    start = 1'b0;
    @(posedge clk); #1;
    check("held_end_idle", {30'd0, busy, done}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
